// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } trk_entry_t;

  localparam int PRI_RR     = 0;
  localparam int PRI_DFIXED = 1;

endpackage

// File: rtl/mem_rsp_tracker.sv
// Shift register that follows each granted read through the memory latency
// so the returning data can be steered to the requester that issued it.
module mem_rsp_tracker
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_t push_owner,
  output logic   head_valid,
  output owner_t head_owner,
  output logic   any_valid
);

  trk_entry_t stage_reg [DEPTH];
  logic [DEPTH-1:0] valid_bits;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= trk_entry_t'{valid: push, owner: push_owner};
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_bits[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign head_valid = stage_reg[DEPTH-1].valid;
  assign head_owner = stage_reg[DEPTH-1].owner;
  assign any_valid  = |valid_bits;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch path and the
// load/store path: one access per cycle, read data routed back to its issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int PRIORITY   = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  owner_t        last_reg;
  logic [SW-1:0] starve_reg;
  logic          if_win;
  logic          d_win;
  logic          head_valid;
  owner_t        head_owner;
  logic          any_valid;

  // Grant decision; everything is forced idle while reset is held.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (!reset) begin
      if (if_req && d_req) begin
        if (PRIORITY == PRI_RR) begin
          if_win = (last_reg == OWN_D);
        end else begin
          if_win = (starve_reg == SW'(STARVE_MAX));
        end
        d_win = !if_win;
      end else begin
        if_win = if_req;
        d_win  = d_req;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_win) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (d_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg   <= OWN_D;
      starve_reg <= '0;
    end else begin
      if (if_win) begin
        last_reg <= OWN_IF;
      end else if (d_win) begin
        last_reg <= OWN_D;
      end
      // Counter never passes STARVE_MAX: reaching it forces the fetch grant.
      if ((PRIORITY == PRI_DFIXED) && if_req && !if_win) begin
        starve_reg <= starve_reg + 1'b1;
      end else begin
        starve_reg <= '0;
      end
    end
  end

  mem_rsp_tracker #(
    .DEPTH(MEM_LAT)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .push      (if_win || (d_win && !d_we)),
    .push_owner(if_win ? OWN_IF : OWN_D),
    .head_valid(head_valid),
    .head_owner(head_owner),
    .any_valid (any_valid)
  );

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign if_rvalid = !reset && head_valid && (head_owner == OWN_IF);
  assign d_rvalid  = !reset && head_valid && (head_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign busy      = !reset && any_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RR lat1, RR lat2, fixed-priority
// lat1) share the stimulus; a queue model checks them every cycle.
module tb_mem_port_arbiter;

  localparam int SM = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic [2:0]       if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [2:0][31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0][3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0000_0013;
      32'h00:  return 32'h0000_000A;
      32'h40:  return 32'h0000_000B;
      32'h04:  return 32'h0000_000C;
      default: return {16'hD0D0, a[15:0]};
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      logic [31:0] p0, p1;
      // Memory stand-in: returns word_of(addr) MEM_LAT cycles after a read strobe,
      // junk otherwise so un-gated rdata shows up.
      always @(posedge clk) begin
        p0 <= (mem_en[gi] && !mem_we[gi]) ? word_of(mem_addr[gi]) : 32'h5A5A_5A5A;
        p1 <= p0;
      end
      assign mem_rdata[gi] = (gi == 1) ? p1 : p0;

      mem_port_arbiter #(
        .AW(32), .DW(32),
        .MEM_LAT(gi == 1 ? 2 : 1),
        .PRIORITY(gi == 2 ? 1 : 0),
        .STARVE_MAX(SM)
      ) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[gi]),
        .if_rvalid(if_rvalid[gi]), .if_rdata(if_rdata[gi]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt[gi]), .d_rvalid(d_rvalid[gi]), .d_rdata(d_rdata[gi]),
        .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_be(mem_be[gi]),
        .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]),
        .busy(busy[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding reads as {dut, owner, data, due cycle}.
  typedef struct {
    int          dut;
    bit          own_d;
    logic [31:0] data;
    int          due;
  } rd_t;

  rd_t pend[$];
  int  lat_of [3] = '{1, 2, 1};
  int  pri_of [3] = '{0, 0, 1};
  bit  last_if [3] = '{1'b0, 1'b0, 1'b0};
  int  starve [3] = '{0, 0, 0};
  int  t = 0;

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      bit e_if, e_d, ret, ret_d, e_busy;
      logic [31:0] ret_data;
      int k;
      e_if = 1'b0; e_d = 1'b0;
      if (!reset) begin
        if (if_req && d_req) begin
          e_if = (pri_of[g] == 0) ? !last_if[g] : (starve[g] == SM);
          e_d  = !e_if;
        end else begin
          e_if = if_req;
          e_d  = d_req;
        end
      end
      k = -1;
      for (int j = 0; j < pend.size(); j++) begin
        if (k < 0 && pend[j].dut == g) k = j;
      end
      ret      = !reset && (k >= 0) && (pend[k].due == t);
      ret_d    = ret ? pend[k].own_d : 1'b0;
      ret_data = ret ? pend[k].data : 32'h0;
      e_busy   = !reset && (k >= 0);

      chk($sformatf("u%0d.gnt", g), {30'b0, if_gnt[g], d_gnt[g]}, {30'b0, e_if, e_d});
      chk($sformatf("u%0d.mem_en", g), {31'b0, mem_en[g]}, {31'b0, e_if | e_d});
      chk($sformatf("u%0d.mem_we", g), {31'b0, mem_we[g]}, {31'b0, e_d & d_we});
      chk($sformatf("u%0d.mem_be", g), {28'b0, mem_be[g]}, e_d ? {28'b0, d_be} : 32'h0);
      chk($sformatf("u%0d.mem_addr", g), mem_addr[g], e_if ? if_addr : (e_d ? d_addr : 32'h0));
      chk($sformatf("u%0d.mem_wdata", g), mem_wdata[g], e_d ? d_wdata : 32'h0);
      chk($sformatf("u%0d.if_rvalid", g), {31'b0, if_rvalid[g]}, {31'b0, ret & !ret_d});
      chk($sformatf("u%0d.if_rdata", g), if_rdata[g], (ret && !ret_d) ? ret_data : 32'h0);
      chk($sformatf("u%0d.d_rvalid", g), {31'b0, d_rvalid[g]}, {31'b0, ret & ret_d});
      chk($sformatf("u%0d.d_rdata", g), d_rdata[g], (ret && ret_d) ? ret_data : 32'h0);
      chk($sformatf("u%0d.busy", g), {31'b0, busy[g]}, {31'b0, e_busy});

      if (ret) pend.delete(k);
      if (reset) begin
        for (int j = pend.size() - 1; j >= 0; j--) begin
          if (pend[j].dut == g) pend.delete(j);
        end
        last_if[g] = 1'b0;
        starve[g]  = 0;
      end else begin
        if (e_if) pend.push_back('{g, 1'b0, word_of(if_addr), t + lat_of[g]});
        if (e_d && !d_we) pend.push_back('{g, 1'b1, word_of(d_addr), t + lat_of[g]});
        if (e_if) last_if[g] = 1'b1;
        else if (e_d) last_if[g] = 1'b0;
        if (pri_of[g] == 1) starve[g] = (if_req && !e_if) ? starve[g] + 1 : 0;
      end
    end
    t++;
  end

  task automatic set_in(input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dw);
    reset = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dw;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat_rr;
    logic [7:0] pat_fp;
    pat_rr = 8'b0101_0101;  // bit i = fetch wins step i, round-robin
    pat_fp = 8'b1000_1000;  // fixed priority, STARVE_MAX=3

    // Reset with both requests active: everything must stay quiet.
    set_in(1, 1, 32'h10, 1, 1, 4'hF, 32'h20, 32'h1111_2222);
    @(negedge clk);
    chk("rst.if_gnt", {31'b0, if_gnt[0]}, 32'h0);
    chk("rst.mem_addr", mem_addr[0], 32'h0);
    chk("rst.busy", {31'b0, busy[0]}, 32'h0);
    next_cycle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    next_cycle();

    // Single fetch read, latency 1.
    set_in(0, 1, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1.if_gnt", {31'b0, if_gnt[0]}, 32'h1);
    chk("t1.mem_en", {31'b0, mem_en[0]}, 32'h1);
    chk("t1.mem_we", {31'b0, mem_we[0]}, 32'h0);
    chk("t1.mem_addr", mem_addr[0], 32'h10);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1.if_rvalid", {31'b0, if_rvalid[0]}, 32'h1);
    chk("t1.if_rdata", if_rdata[0], 32'h13);
    chk("t1.d_rvalid", {31'b0, d_rvalid[0]}, 32'h0);
    next_cycle();
    @(negedge clk);
    next_cycle();

    // Both requesting continuously after reset.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 32'h4, 1, 0, 4'h0, 32'h40, 32'h0);
      @(negedge clk);
      chk($sformatf("t2.if_gnt[%0d]", i), {31'b0, if_gnt[0]}, {31'b0, pat_rr[i]});
      chk($sformatf("t2.d_gnt[%0d]", i), {31'b0, d_gnt[0]}, {31'b0, !pat_rr[i]});
      chk($sformatf("t3.if_gnt[%0d]", i), {31'b0, if_gnt[2]}, {31'b0, pat_fp[i]});
      chk($sformatf("t3.d_gnt[%0d]", i), {31'b0, d_gnt[2]}, {31'b0, !pat_fp[i]});
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      next_cycle();
    end

    // Store: completes in the grant cycle, never returns.
    set_in(0, 0, 0, 1, 1, 4'hF, 32'h20, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t4.d_gnt", {31'b0, d_gnt[0]}, 32'h1);
    chk("t4.mem_we", {31'b0, mem_we[0]}, 32'h1);
    chk("t4.mem_be", {28'b0, mem_be[0]}, 32'hF);
    chk("t4.mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk("t4.mem_addr", mem_addr[0], 32'h20);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("t4.d_rvalid+%0d", i + 1), {31'b0, d_rvalid[0]}, 32'h0);
      chk($sformatf("t4.busy+%0d", i + 1), {31'b0, busy[0]}, 32'h0);
      next_cycle();
    end

    // Latency-2 read killed by reset one cycle after grant.
    set_in(0, 1, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5.if_gnt", {31'b0, if_gnt[1]}, 32'h1);
    next_cycle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("t5.if_rvalid@%0d", i + 2), {31'b0, if_rvalid[1]}, 32'h0);
      chk($sformatf("t5.busy@%0d", i + 2), {31'b0, busy[1]}, 32'h0);
      next_cycle();
    end

    // Back-to-back reads through the latency-2 instance.
    set_in(0, 1, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    next_cycle();
    set_in(0, 0, 0, 1, 0, 4'h0, 32'h40, 32'h0);
    @(negedge clk);
    next_cycle();
    set_in(0, 1, 32'h4, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6.if_rvalid@2", {31'b0, if_rvalid[1]}, 32'h1);
    chk("t6.if_rdata@2", if_rdata[1], 32'hA);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6.d_rvalid@3", {31'b0, d_rvalid[1]}, 32'h1);
    chk("t6.d_rdata@3", d_rdata[1], 32'hB);
    chk("t6.if_rvalid@3", {31'b0, if_rvalid[1]}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t6.if_rvalid@4", {31'b0, if_rvalid[1]}, 32'h1);
    chk("t6.if_rdata@4", if_rdata[1], 32'hC);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      next_cycle();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous instruction/data memory between two requesters: the fetch path (reads only) and the load/store path (reads and writes).
- The control unit's fetch and load/store sequencing both issue requests through this block.
- It arbitrates one access per cycle and tracks each in-flight read through the memory latency.
- It returns read data to the requester that issued the read.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width; must be a multiple of 8
MEM_LAT, 1, memory read latency in cycles (>=1)
PRIORITY, 0, 0 = round-robin; 1 = load/store fixed priority with starvation guard
STARVE_MAX, 4, in PRIORITY=1, consecutive denied fetch cycles before fetch is forced (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  AW  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DW  fetch read data
d_req  in  1  load/store request
d_we  in  1  1 = store, 0 = load
d_be  in  DW/8  store byte enables
d_addr  in  AW  load/store address
d_wdata  in  DW  store data
d_gnt  out  1  load/store request accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  DW  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  DW/8  memory byte enables
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after a read strobe
busy  out  1  at least one read in flight

Behaviour:
- Reset: synchronous, active-high, on clk.
  - All in-flight tracker entries are cleared.
  - Round-robin pointer favours fetch.
  - Starvation counter = 0.
  - No rvalid is ever produced for reads issued before reset, including reads granted in the cycle reset asserts.
- Output values while reset is high: gnt, rvalid, mem_en, mem_we and busy = 0; rdata, mem_be, mem_addr and mem_wdata = 0.
- Requester contract: hold req and all request fields stable until gnt. gnt is combinational from current req and registered arbiter state, and is asserted in the same cycle as the accepted access.
- At most one gnt per cycle.
- mem_en = if_gnt | d_gnt.
- mem_* fields are muxed from the winner. Fetch always drives mem_we=0 and mem_be=0.
- With no winner, mem_* = 0.
- PRIORITY=0 (round-robin):
  - Single requester always wins.
  - When both request, the requester not granted most recently wins.
  - The pointer updates only on a grant.
- PRIORITY=1 (fixed priority with starvation guard):
  - Load/store wins whenever d_req, except as below.
  - The starvation counter increments each cycle if_req is high but not granted. It clears on if_gnt or when if_req is low.
  - When the counter equals STARVE_MAX, fetch wins that cycle regardless of d_req.
- Store (d_we=1): complete in the grant cycle; no rvalid and no tracker entry.
- Read (fetch, or load with d_we=0): push {valid=1, owner} into a MEM_LAT-deep shift register in the grant cycle.
  - When an entry reaches the head, the owner's rvalid=1 for exactly one cycle, and that owner's rdata = mem_rdata.
  - The other rdata stays 0; rdata = 0 whenever its rvalid = 0.
- Reads are fully pipelined: one read may be granted every cycle, and returns arrive in grant order.
- busy = OR of the tracker valid bits.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum {OWN_IF, OWN_D}
  - tracker entry struct {valid, owner_t owner}
  - the arbitration mode constants PRI_RR=0, PRI_DFIXED=1
- Sub-module mem_rsp_tracker: MEM_LAT-deep shift register of entries, with push/owner inputs, head valid/owner outputs and an any-valid output.
- The arbiter and mux stay in the top.

Test Plan:
1. MEM_LAT=1; if_req with if_addr=0x10; memory returns 0x00000013 -> if_gnt=1 and mem_en=1, mem_we=0, mem_addr=0x10 in the same cycle; next cycle if_rvalid=1, if_rdata=0x00000013; d_rvalid=0.
2. PRIORITY=0; after reset, hold if_req and d_req (load) for 4 cycles -> winners IF, D, IF, D; exactly one gnt per cycle.
3. PRIORITY=1, STARVE_MAX=3; hold both requests -> winners D, D, D, IF, D, D, D, IF.
4. Store with d_we=1, d_be=0xF, d_addr=0x20, d_wdata=0xDEADBEEF -> same cycle d_gnt=1, mem_we=1, mem_be=0xF, mem_wdata=0xDEADBEEF; no d_rvalid for 5 following cycles; busy=0.
5. MEM_LAT=2; grant a fetch read at cycle 0, then assert reset at cycle 1 -> no if_rvalid at cycle 2 or later; busy=0 after reset.
6. MEM_LAT=2, PRIORITY=0; back-to-back reads IF(0x0), D(0x40), IF(0x4) with memory returning 0xA, 0xB, 0xC -> if_rvalid/0xA at cycle 2, d_rvalid/0xB at cycle 3, if_rvalid/0xC at cycle 4.
